// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and constants for the single-car elevator
//                controller: FSM state encoding, direction codes and a small
//                helper used for sizing the shared travel/door timer.
//  Contents    : state_t      - IDLE / MOVE / DOOR
//                c_DIR_*      - 2-bit direction codes driven on 'direction'
//                max_int()    - larger of two integers
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic [1:0] c_DIR_IDLE = 2'b00;
    localparam logic [1:0] c_DIR_UP   = 2'b01;
    localparam logic [1:0] c_DIR_DOWN = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_req_scan.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_req_scan
//  Description : Combinational request scanner. Given the pending-request
//                bitmap and a reference floor, reports whether that floor is
//                itself requested and whether any request lies above/below it.
//  Ports       : i_pending  in   NUM_FLOORS  outstanding request bitmap
//                i_floor    in   FLOOR_W     reference floor
//                o_here     out  1           i_pending[i_floor]
//                o_above    out  1           any request at a floor > i_floor
//                o_below    out  1           any request at a floor < i_floor
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]    i_floor,
    output logic                  o_here,
    output logic                  o_above,
    output logic                  o_below
);

    logic [NUM_FLOORS-1:0] w_here_mask;
    logic [NUM_FLOORS-1:0] w_above_mask;
    logic [NUM_FLOORS-1:0] w_below_mask;

    // Per-floor compare against the reference floor; the three masks are then
    // OR-reduced. Comparing per bit avoids an out-of-range variable index when
    // NUM_FLOORS is not a power of two.
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_bit
        assign w_here_mask[gi]  = i_pending[gi] && (i_floor == FLOOR_W'(gi));
        assign w_above_mask[gi] = i_pending[gi] && (i_floor <  FLOOR_W'(gi));
        assign w_below_mask[gi] = i_pending[gi] && (i_floor >  FLOOR_W'(gi));
    end

    assign o_here  = |w_here_mask;
    assign o_above = |w_above_mask;
    assign o_below = |w_below_mask;

endmodule
`default_nettype wire

// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_ctrl
//  Description : Single-car elevator controller. Latches floor requests into a
//                pending bitmap and serves them SCAN-style: keep the current
//                direction while requests lie ahead, then reverse. Times floor
//                travel and door dwell with one shared down-counter and keeps
//                the door open while the car is over weight.
//  Ports       : clk          in   1           clock
//                reset        in   1           asynchronous reset, active low
//                req_valid    in   1           request strobe
//                req_floor    in   FLOOR_W     requested floor
//                weight       in   WEIGHT_W    current load
//                cur_floor    out  FLOOR_W     floor the car is at / last left
//                direction    out  2           00 idle, 01 up, 10 down
//                moving       out  1           car travelling (MOVE)
//                door_open    out  1           door open (DOOR)
//                arrived      out  1           1-cycle pulse when a floor is served
//                over_weight  out  1           registered weight > MAX_WEIGHT
//                pending      out  NUM_FLOORS  outstanding request bitmap
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 8,
    parameter int FLOOR_W      = $clog2(NUM_FLOORS),
    parameter int TRAVEL_TICKS = 5000,
    parameter int DOOR_TICKS   = 5000,
    parameter int WEIGHT_W     = 11,
    parameter int MAX_WEIGHT   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic [WEIGHT_W-1:0]   weight,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [1:0]            direction,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrived,
    output logic                  over_weight,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int                   c_TIMER_W       = $clog2(max_int(TRAVEL_TICKS, DOOR_TICKS) + 1);
    localparam logic [c_TIMER_W-1:0] c_TRAVEL_RELOAD = c_TIMER_W'(TRAVEL_TICKS - 1);
    localparam logic [c_TIMER_W-1:0] c_DOOR_RELOAD   = c_TIMER_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0]   c_TOP_FLOOR     = FLOOR_W'(NUM_FLOORS - 1);

    state_t                r_state;
    logic [c_TIMER_W-1:0]  r_timer;
    logic [FLOOR_W-1:0]    r_cur_floor;
    logic [1:0]            r_direction;
    logic                  r_arrived;
    logic                  r_over_weight;
    logic [NUM_FLOORS-1:0] r_pending;

    logic                  w_over_weight;
    logic                  w_req_in_range;
    logic                  w_req_at_open_door;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [FLOOR_W-1:0]    w_next_floor;
    logic                  w_at_end;
    logic                  w_here;
    logic                  w_above;
    logic                  w_below;
    logic                  w_next_here;
    logic                  w_next_above;
    logic                  w_next_below;
    logic                  w_next_ahead;
    logic                  w_arrive;
    logic [FLOOR_W-1:0]    w_arrive_floor;
    logic                  w_timer_zero;

    assign w_over_weight = (64'(weight) > 64'(MAX_WEIGHT));
    assign w_timer_zero  = (r_timer == '0);

    // ------------------------------------------------------------------------
    // Request capture. A call for the floor whose door is already open is not
    // recorded; instead it restarts the dwell timer.
    // ------------------------------------------------------------------------
    assign w_req_in_range     = req_valid && (int'(req_floor) < NUM_FLOORS);
    assign w_req_at_open_door = w_req_in_range && (r_state == DOOR) && (req_floor == r_cur_floor);
    assign w_set              = (w_req_in_range && !w_req_at_open_door)
                                ? (NUM_FLOORS'(1) << req_floor) : '0;

    // ------------------------------------------------------------------------
    // Scan the bitmap around the current floor and around the floor the car
    // would reach at the end of the current travel interval.
    // ------------------------------------------------------------------------
    assign w_next_floor = (r_direction == c_DIR_DOWN) ? (r_cur_floor - FLOOR_W'(1))
                                                      : (r_cur_floor + FLOOR_W'(1));

    // MOVE with nowhere further to go in the travel direction; a zero
    // direction cannot occur in MOVE but is folded in so the car never wraps.
    assign w_at_end = ((r_direction == c_DIR_UP)   && (r_cur_floor == c_TOP_FLOOR)) ||
                      ((r_direction == c_DIR_DOWN) && (r_cur_floor == '0))          ||
                      (r_direction == c_DIR_IDLE);

    elevator_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan_cur (
        .i_pending  (r_pending),
        .i_floor    (r_cur_floor),
        .o_here     (w_here),
        .o_above    (w_above),
        .o_below    (w_below)
    );

    elevator_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan_next (
        .i_pending  (r_pending),
        .i_floor    (w_next_floor),
        .o_here     (w_next_here),
        .o_above    (w_next_above),
        .o_below    (w_next_below)
    );

    assign w_next_ahead = (r_direction == c_DIR_DOWN) ? w_next_below : w_next_above;

    // ------------------------------------------------------------------------
    // Arrival event: the edge on which a pending floor is served. It drives
    // the bitmap clear, the 'arrived' pulse and the FSM's entry into DOOR.
    // ------------------------------------------------------------------------
    always_comb begin
        w_arrive       = 1'b0;
        w_arrive_floor = r_cur_floor;
        if (r_state == IDLE) begin
            w_arrive = w_here;
        end else if ((r_state == MOVE) && w_timer_zero) begin
            if (w_at_end) begin
                w_arrive = w_here;
            end else begin
                w_arrive       = w_next_here;
                w_arrive_floor = w_next_floor;
            end
        end
    end

    assign w_clr = w_arrive ? (NUM_FLOORS'(1) << w_arrive_floor) : '0;

    // ------------------------------------------------------------------------
    // FSM, timer and output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_cur_floor   <= '0;
            r_direction   <= c_DIR_IDLE;
            r_arrived     <= 1'b0;
            r_over_weight <= 1'b0;
            r_pending     <= '0;
        end else begin
            // Clear beats set on the same bit: the door opening now serves it.
            r_pending     <= (r_pending | w_set) & ~w_clr;
            r_over_weight <= w_over_weight;
            r_arrived     <= w_arrive;

            case (r_state)
                IDLE: begin
                    if (w_arrive) begin
                        r_state     <= DOOR;
                        r_timer     <= c_DOOR_RELOAD;
                        r_direction <= c_DIR_IDLE;
                    end else if (!r_over_weight && w_above) begin
                        r_state     <= MOVE;
                        r_timer     <= c_TRAVEL_RELOAD;
                        r_direction <= c_DIR_UP;
                    end else if (!r_over_weight && w_below) begin
                        r_state     <= MOVE;
                        r_timer     <= c_TRAVEL_RELOAD;
                        r_direction <= c_DIR_DOWN;
                    end else begin
                        r_timer     <= '0;
                        r_direction <= c_DIR_IDLE;
                    end
                end

                MOVE: begin
                    if (!w_timer_zero) begin
                        r_timer <= r_timer - c_TIMER_W'(1);
                    end else if (w_at_end) begin
                        if (w_arrive) begin
                            r_state <= DOOR;
                            r_timer <= c_DOOR_RELOAD;
                        end else begin
                            r_state     <= IDLE;
                            r_timer     <= '0;
                            r_direction <= c_DIR_IDLE;
                        end
                    end else begin
                        r_cur_floor <= w_next_floor;
                        if (w_arrive) begin
                            r_state <= DOOR;
                            r_timer <= c_DOOR_RELOAD;
                        end else if (!w_next_ahead) begin
                            r_state     <= IDLE;
                            r_timer     <= '0;
                            r_direction <= c_DIR_IDLE;
                        end else begin
                            r_timer <= c_TRAVEL_RELOAD;
                        end
                    end
                end

                DOOR: begin
                    if (r_over_weight || w_req_at_open_door) begin
                        r_timer <= c_DOOR_RELOAD;
                    end else if (!w_timer_zero) begin
                        r_timer <= r_timer - c_TIMER_W'(1);
                    end else if ((r_direction == c_DIR_DOWN) ? w_below : w_above) begin
                        // Requests still ahead: continue the sweep.
                        r_state <= MOVE;
                        r_timer <= c_TRAVEL_RELOAD;
                        r_direction <= (r_direction == c_DIR_DOWN) ? c_DIR_DOWN : c_DIR_UP;
                    end else if ((r_direction == c_DIR_DOWN) ? w_above : w_below) begin
                        // Only requests behind: reverse.
                        r_state <= MOVE;
                        r_timer <= c_TRAVEL_RELOAD;
                        r_direction <= (r_direction == c_DIR_DOWN) ? c_DIR_UP : c_DIR_DOWN;
                    end else begin
                        r_state     <= IDLE;
                        r_timer     <= '0;
                        r_direction <= c_DIR_IDLE;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_timer     <= '0;
                    r_direction <= c_DIR_IDLE;
                end
            endcase
        end
    end

    assign cur_floor   = r_cur_floor;
    assign direction   = r_direction;
    assign moving      = (r_state == MOVE);
    assign door_open   = (r_state == DOOR);
    assign arrived     = r_arrived;
    assign over_weight = r_over_weight;
    assign pending     = r_pending;

endmodule
`default_nettype wire
